fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Upstream neighbour of InstructionMemory: owns the program counter and drives the 64-bit fetch Address.
- Captures the returned 32-bit Instruction together with its PC into a fetch register, which feeds decode through a valid/ready handshake.
- Handles branch redirects with a flush, stalls when decode back-pressures, and halts on a fetch past END_PC or on a misaligned target.

Parameters:
- RESET_PC, 64'h038, PC value loaded on reset; first instruction of the test program.
- END_PC, 64'h06c, first address not in the program; fetching here enters HALT.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Address  output  64  fetch address to InstructionMemory; always equals the PC register.
- Instruction  input  32  instruction word returned combinationally by InstructionMemory for Address.
- Redirect  input  1  branch/jump resolved taken this cycle.
- RedirectTarget  input  64  new PC when Redirect=1.
- IF_Valid  output  1  fetch register holds a valid instruction for decode.
- IF_Ready  input  1  decode accepts the fetch register this cycle.
- IF_Instr  output  32  captured instruction.
- IF_PC  output  64  PC of IF_Instr.
- Halted  output  1  unit is in HALT; no further fetches.
- Fault  output  1  sticky; set on a misaligned RedirectTarget.
- FetchCount  output  CNT_W  number of instructions handed to decode (handshakes completed); saturates at all-ones.

Behaviour:
- Reset (Reset=1 at an edge; takes effect even mid-operation):
  - PC=RESET_PC, state=FETCH.
  - IF_Valid=0, IF_Instr=0, IF_PC=0.
  - Halted=0, Fault=0, FetchCount=0.
- Address = PC at all times; Instruction is sampled the same cycle (zero latency).
- accept = IF_Valid & IF_Ready.
- Capture condition: state=FETCH, Redirect=0, PC != END_PC, and (IF_Valid=0 or accept=1).
- On capture: IF_Instr<=Instruction, IF_PC<=PC, IF_Valid<=1, PC<=PC+4.
  - Steady-state throughput: 1 instruction/cycle.
  - Instruction-to-IF_Instr latency: 1 cycle.
- accept without capture: IF_Valid<=0.
- FetchCount increments on every accept, except in cycles with Redirect=1 (the in-flight instruction is flushed, not handed over).
- PC arithmetic is modulo 2^64; wrap-around from all-ones is legal and is not a fault.
- States:
  - FETCH: normal operation.
    - IF_Valid=1 and IF_Ready=0 -> STALL.
    - PC==END_PC with no Redirect -> HALT; Halted=1 from the next cycle; the instruction at END_PC is not captured.
  - STALL: PC and the fetch register hold their values; IF_Valid stays 1; no capture.
    - IF_Ready=1 -> FETCH, capturing in the same cycle as the accept; no bubble.
  - HALT: PC frozen; a valid fetch register still drains on IF_Ready. Left only via Reset or Redirect.
- Redirect (highest priority after Reset; legal in any state):
  - RedirectTarget[1:0]==0: PC<=RedirectTarget, IF_Valid<=0 (flush, one bubble), state<=FETCH, Halted<=0; no capture that cycle.
  - RedirectTarget[1:0]!=0: Fault<=1, Halted<=1, state<=HALT, IF_Valid<=0, PC unchanged.
  - Fault clears only on Reset.
- Simultaneous accept and Redirect: the flush wins; the instruction is counted as not delivered.
- Outputs are registered, except Address (the PC register itself).

Test Plan:
- Reset, IF_Ready=1 held, InstructionMemory attached:
  - Address steps 0x038, 0x03c, ... 0x068; IF_Instr sequence starts 0x8B1F03E9, 0xB2048D29 and ends 0xF84283EA.
  - Halted=1 one cycle after Address=0x06c; FetchCount=13.
- IF_Ready=0 for 3 cycles after IF_PC=0x040:
  - IF_PC/IF_Instr hold 0x040/0xD37F3129 and Address holds 0x044.
  - On release, 0x044 is captured in the same cycle; no duplicate and no gap in the IF_PC sequence.
- Redirect=1, RedirectTarget=0x050 while IF_PC=0x044 is valid with IF_Ready=1:
  - Next cycle IF_Valid=0; the following cycle IF_PC=0x050, IF_Instr=0xD37F3129.
  - FetchCount does not count 0x044.
- Redirect to 0x03e:
  - Fault=1 and Halted=1 next cycle; IF_Valid=0; PC frozen.
  - A later aligned Redirect to 0x038 resumes fetch with Fault still 1.
- Redirect to 0x038 while in HALT:
  - Halted falls; fetch restarts at 0x038.
- Reset asserted during STALL with IF_Valid=1:
  - Next cycle IF_Valid=0, Address=0x038, FetchCount=0, state FETCH.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and fetch register feeding decode over a valid/ready handshake
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h038,
  parameter logic [63:0] END_PC = 64'h06c,
  parameter int CNT_W = 32
) (
  input  logic Clk,
  input  logic Reset,
  output logic [63:0] Address,
  input  logic [31:0] Instruction,
  input  logic Redirect,
  input  logic [63:0] RedirectTarget,
  output logic IF_Valid,
  input  logic IF_Ready,
  output logic [31:0] IF_Instr,
  output logic [63:0] IF_PC,
  output logic Halted,
  output logic Fault,
  output logic [CNT_W-1:0] FetchCount
);
  typedef enum logic [1:0] {FETCH, STALL, HALT} state_t;
  state_t state, state_n;
  logic [63:0] pc;
  logic accept, capture, misaligned;
  assign Address = pc;
  assign accept = IF_Valid & IF_Ready;
  assign misaligned = |RedirectTarget[1:0];
  // a stall release captures in the same cycle as the accept, so no bubble
  assign capture = !Redirect && pc != END_PC &&
                   ((state == FETCH && (!IF_Valid || accept)) || (state == STALL && accept));
  always_comb begin
    state_n = FETCH;
    state_n = Redirect ? (misaligned ? HALT : FETCH) :
              state == HALT ? HALT :
              (state == FETCH && pc == END_PC) ? HALT :
              (IF_Valid && !IF_Ready) ? STALL : FETCH;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= FETCH;
      pc <= RESET_PC;
      IF_Valid <= 1'b0;
      IF_Instr <= '0;
      IF_PC <= '0;
      Halted <= 1'b0;
      Fault <= 1'b0;
      FetchCount <= '0;
    end else begin
      state <= state_n;
      Halted <= state_n == HALT;
      Fault <= Fault | (Redirect & misaligned);
      if (Redirect && !misaligned) pc <= RedirectTarget;
      else if (capture) pc <= pc + 64'd4;
      if (capture) begin
        IF_Instr <= Instruction;
        IF_PC <= pc;
      end
      IF_Valid <= Redirect ? 1'b0 : capture ? 1'b1 : accept ? 1'b0 : IF_Valid;
      // a flushed instruction is not handed over, so it is not counted
      if (accept && !Redirect && ~&FetchCount) FetchCount <= FetchCount + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench with a behavioural model and per-cycle output comparison
module tb_fetch_unit;
  localparam logic [63:0] END_PC = 64'h06c;
  logic Clk = 0, Reset = 1, Redirect = 0, IF_Ready = 1;
  logic [63:0] RedirectTarget = '0, Address, IF_PC;
  logic [31:0] Instruction, IF_Instr, FetchCount;
  logic IF_Valid, Halted, Fault;
  int n_chk = 0, n_fail = 0;

  fetch_unit dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .Instruction(Instruction),
    .Redirect(Redirect), .RedirectTarget(RedirectTarget), .IF_Valid(IF_Valid),
    .IF_Ready(IF_Ready), .IF_Instr(IF_Instr), .IF_PC(IF_PC), .Halted(Halted),
    .Fault(Fault), .FetchCount(FetchCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem(input logic [63:0] a);
    case (a)
      64'h038: imem = 32'h8B1F03E9;
      64'h03c: imem = 32'hB2048D29;
      64'h040: imem = 32'hD37F3129;
      64'h044: imem = 32'h91000421;
      64'h048: imem = 32'hF9400BE0;
      64'h04c: imem = 32'h8B020020;
      64'h050: imem = 32'hD37F3129;
      64'h054: imem = 32'hCB010042;
      64'h058: imem = 32'hB4000060;
      64'h05c: imem = 32'h17FFFFFD;
      64'h060: imem = 32'hAA0103E2;
      64'h064: imem = 32'hD65F03C0;
      64'h068: imem = 32'hF84283EA;
      default: imem = a[31:0] ^ 32'h5A5A0000;
    endcase
  endfunction

  assign Instruction = imem(Address);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // model: the program is a stream of words at PC, PC+4, ...; one word sits in the
  // fetch slot, a new one enters whenever the slot is empty or being drained
  logic [63:0] m_pc, m_ifpc;
  logic [31:0] m_instr, m_cnt;
  logic m_valid, m_halt, m_fault, m_live = 0;
  always @(posedge Clk) begin
    logic take;
    logic [63:0] old_pc;
    if (Reset) begin
      m_live = 1; m_pc = 64'h038; m_ifpc = 0; m_instr = 0;
      m_valid = 0; m_halt = 0; m_fault = 0; m_cnt = 0;
    end else if (m_live) begin
      take = m_valid && IF_Ready;
      old_pc = m_pc;
      if (Redirect) begin
        m_valid = 0;
        if (RedirectTarget[1:0] == 2'b00) begin
          m_pc = RedirectTarget; m_halt = 0;
        end else begin
          m_fault = 1; m_halt = 1;
        end
      end else begin
        if (take && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
        if (!m_halt && old_pc != END_PC && (!m_valid || take)) begin
          m_instr = imem(old_pc); m_ifpc = old_pc; m_valid = 1; m_pc = old_pc + 4;
        end else if (take) m_valid = 0;
        if (!m_halt && old_pc == END_PC) m_halt = 1;
      end
    end
  end

  always @(negedge Clk) if (m_live) begin
    chk("Address", Address, m_pc);
    chk("IF_Valid", {63'b0, IF_Valid}, {63'b0, m_valid});
    if (m_valid) begin
      chk("IF_Instr", {32'b0, IF_Instr}, {32'b0, m_instr});
      chk("IF_PC", IF_PC, m_ifpc);
    end
    chk("Halted", {63'b0, Halted}, {63'b0, m_halt});
    chk("Fault", {63'b0, Fault}, {63'b0, m_fault});
    chk("FetchCount", {32'b0, FetchCount}, {32'b0, m_cnt});
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    step(); step();
    chk("rst_valid", {63'b0, IF_Valid}, 64'd0);
    chk("rst_addr", Address, 64'h038);
    chk("rst_cnt", {32'b0, FetchCount}, 64'd0);
    chk("rst_halt", {62'b0, Halted, Fault}, 64'd0);
    Reset = 0;
    step();
    chk("first_instr", {32'b0, IF_Instr}, 64'h8B1F03E9);
    chk("first_pc", IF_PC, 64'h038);
    step();
    chk("second_instr", {32'b0, IF_Instr}, 64'hB2048D29);
    for (int i = 0; i < 40 && !Halted; i++) step();
    chk("halt_reached", {63'b0, Halted}, 64'd1);
    chk("halt_cnt", {32'b0, FetchCount}, 64'd13);
    chk("last_instr", {32'b0, IF_Instr}, 64'hF84283EA);
    chk("halt_addr", Address, 64'h06c);
    step(); step();
    chk("halt_frozen", Address, 64'h06c);
    // stall
    Reset = 1; step(); Reset = 0;
    for (int i = 0; i < 20 && !(IF_Valid && IF_PC == 64'h040); i++) step();
    chk("reach_040", IF_PC, 64'h040);
    IF_Ready = 0;
    step(); step(); step();
    chk("stall_pc", IF_PC, 64'h040);
    chk("stall_instr", {32'b0, IF_Instr}, 64'hD37F3129);
    chk("stall_addr", Address, 64'h044);
    chk("stall_valid", {63'b0, IF_Valid}, 64'd1);
    IF_Ready = 1;
    step();
    chk("release_pc", IF_PC, 64'h044);
    chk("release_addr", Address, 64'h048);
    chk("release_cnt", {32'b0, FetchCount}, 64'd3);
    // aligned redirect flushes 0x044
    Redirect = 1; RedirectTarget = 64'h050;
    step();
    Redirect = 0;
    chk("flush_valid", {63'b0, IF_Valid}, 64'd0);
    chk("flush_addr", Address, 64'h050);
    step();
    chk("redir_pc", IF_PC, 64'h050);
    chk("redir_instr", {32'b0, IF_Instr}, 64'hD37F3129);
    chk("redir_cnt", {32'b0, FetchCount}, 64'd3);
    // misaligned redirect
    Redirect = 1; RedirectTarget = 64'h03e;
    step();
    Redirect = 0;
    chk("mis_fault", {63'b0, Fault}, 64'd1);
    chk("mis_halt", {63'b0, Halted}, 64'd1);
    chk("mis_valid", {63'b0, IF_Valid}, 64'd0);
    chk("mis_addr", Address, 64'h054);
    chk("mis_cnt", {32'b0, FetchCount}, 64'd3);
    step(); step();
    chk("mis_frozen", Address, 64'h054);
    Redirect = 1; RedirectTarget = 64'h038;
    step();
    Redirect = 0;
    chk("resume_halt", {63'b0, Halted}, 64'd0);
    chk("resume_fault", {63'b0, Fault}, 64'd1);
    chk("resume_addr", Address, 64'h038);
    step();
    chk("resume_pc", IF_PC, 64'h038);
    // redirect out of end-of-program halt
    for (int i = 0; i < 40 && !Halted; i++) step();
    chk("halt2", {63'b0, Halted}, 64'd1);
    Redirect = 1; RedirectTarget = 64'h038;
    step();
    Redirect = 0;
    chk("unhalt", {63'b0, Halted}, 64'd0);
    chk("unhalt_addr", Address, 64'h038);
    step();
    chk("unhalt_pc", IF_PC, 64'h038);
    // reset during stall
    IF_Ready = 0;
    step(); step();
    chk("pre_rst_valid", {63'b0, IF_Valid}, 64'd1);
    Reset = 1;
    step();
    chk("mid_rst_valid", {63'b0, IF_Valid}, 64'd0);
    chk("mid_rst_addr", Address, 64'h038);
    chk("mid_rst_cnt", {32'b0, FetchCount}, 64'd0);
    chk("mid_rst_fault", {63'b0, Fault}, 64'd0);
    Reset = 0; IF_Ready = 1;
    step();
    chk("post_rst_pc", IF_PC, 64'h038);
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
